// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: arbiter state encoding and small index helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable; also imported by the master-side decoder.
package xbar_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // One bit of a one-hot vector: high when bit position 'pos' equals index 'idx'.
    function automatic logic xbar_onehot_bit(input int idx, input int pos);
        return (idx == pos);
    endfunction

    // Index 'base + off', wrapped into the range 0..n-1.
    function automatic int xbar_rot_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

    // Next index after 'idx', wrapping to 0 after n-1.
    function automatic int xbar_wrap_inc(input int idx, input int n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/xbar_rr_pick.sv
// Rotate-priority picker: first unmasked requester at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the winner is taken.
//
// Ports:
//   req     per-master request vector
//   mask    masters excluded from this pick
//   ptr     highest-priority index for this pick
//   win     winning index (0 when win_vld is low)
//   win_vld at least one unmasked request present
module xbar_rr_pick
    import xbar_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    localparam int SEL_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] mask,
    input  logic [SEL_W-1:0]       ptr,
    output logic [SEL_W-1:0]       win,
    output logic                   win_vld
);

    logic [NUM_MASTERS-1:0] eff_req;
    logic [SEL_W-1:0]       cand;

    assign eff_req = req & ~mask;

    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = SEL_W'(xbar_rot_idx(int'(ptr), i, NUM_MASTERS));
            if (!win_vld && eff_req[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
    end

endmodule

// File: rtl/xbar_wrr_slave_arbiter.sv
// Per-slave weighted round-robin arbiter choosing which master drives the slave mux.
// Latency: request to registered grant is 1 cycle; one idle cycle between successive owners.
// Backpressure: a granted master keeps the slave for up to WEIGHT acks, or longer while locked; no preemption.
//
// Ports:
//   i_Clk, i_Rst_n  clock, asynchronous active-low reset
//   i_Req, i_Lock   per-master request and lock levels
//   i_Ack           slave finished one transfer for the current owner
//   o_Gnt           registered one-hot grant (zero between owners)
//   o_MuxSel        registered index of the current or most recent owner
//   o_Busy          high while in the GRANT state
//   o_Timeout       one-cycle pulse when a locked owner is forcibly released
//
// Optional feature macro: XBAR_ARB_LOCK_TIMEOUT_EN adds the lock watchdog and
// the block mask that keeps a timed-out master out until it drops its request.
module xbar_wrr_slave_arbiter
    import xbar_pkg::*;
#(
    parameter  int NUM_MASTERS  = 2,
    parameter  int WEIGHT       = 4,
    parameter  int LOCK_TIMEOUT = 256,
    localparam int SEL_W        = $clog2(NUM_MASTERS)
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic [NUM_MASTERS-1:0] i_Req,
    input  logic [NUM_MASTERS-1:0] i_Lock,
    input  logic                   i_Ack,
    output logic [NUM_MASTERS-1:0] o_Gnt,
    output logic [SEL_W-1:0]       o_MuxSel,
    output logic                   o_Busy,
    output logic                   o_Timeout
);

    localparam int CNT_W = $clog2(WEIGHT + 1);

    if (NUM_MASTERS < 2) begin : g_chk_masters
        $error("NUM_MASTERS must be at least 2");
    end
    if (WEIGHT < 1) begin : g_chk_weight
        $error("WEIGHT must be at least 1");
    end
    if (LOCK_TIMEOUT < 2) begin : g_chk_timeout
        $error("LOCK_TIMEOUT must be at least 2");
    end

    arb_state_t             state_q, state_n;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_n;
    logic [SEL_W-1:0]       sel_q, sel_n;
    logic [SEL_W-1:0]       ptr_q, ptr_n;
    logic [CNT_W-1:0]       beat_q, beat_n;
    logic                   tout_q, tout_n;
    logic [NUM_MASTERS-1:0] blk_q;

    logic                   pick_vld;
    logic [SEL_W-1:0]       pick_idx;
    logic                   own_req;
    logic                   own_lock;
    logic                   to_fire;
    logic                   release_c;

    // sel_q is the owner throughout GRANT, so it doubles as the owner index.
    assign own_req  = i_Req[sel_q];
    assign own_lock = i_Lock[sel_q];

    xbar_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_pick (
        .req     (i_Req),
        .mask    (blk_q),
        .ptr     (ptr_q),
        .win     (pick_idx),
        .win_vld (pick_vld)
    );

`ifdef XBAR_ARB_LOCK_TIMEOUT_EN
    localparam int TO_W = $clog2(LOCK_TIMEOUT);

    logic [TO_W-1:0]        to_q, to_n;
    logic [NUM_MASTERS-1:0] blk_n;

    // Watchdog counts locked cycles without progress; any ack restarts it.
    always_comb begin
        to_n    = to_q;
        to_fire = 1'b0;
        if (state_q == ARB_IDLE || i_Ack) begin
            to_n = '0;
        end else if (own_lock) begin
            if (to_q == TO_W'(LOCK_TIMEOUT - 1)) begin
                to_fire = 1'b1;
                to_n    = '0;
            end else begin
                to_n = to_q + TO_W'(1);
            end
        end
    end

    // A master's block bit clears as soon as its request is seen low.
    always_comb begin
        blk_n = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            blk_n[i] = (blk_q[i] & i_Req[i]) |
                       (to_fire & xbar_onehot_bit(int'(sel_q), i));
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            to_q  <= '0;
            blk_q <= '0;
        end else begin
            to_q  <= to_n;
            blk_q <= blk_n;
        end
    end
`else
    assign to_fire = 1'b0;
    assign blk_q   = '0;
`endif

    always_comb begin
        state_n   = state_q;
        gnt_n     = gnt_q;
        sel_n     = sel_q;
        ptr_n     = ptr_q;
        beat_n    = beat_q;
        tout_n    = 1'b0;
        release_c = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_n = ARB_GRANT;
                    sel_n   = pick_idx;
                    beat_n  = '0;
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        gnt_n[i] = xbar_onehot_bit(int'(pick_idx), i);
                    end
                end
            end
            ARB_GRANT: begin
                if (i_Ack && beat_q != CNT_W'(WEIGHT)) begin
                    beat_n = beat_q + CNT_W'(1);
                end
                // Quota check uses the post-update count, so the WEIGHT-th ack releases on its own edge.
                release_c = !own_req ||
                            (!own_lock && beat_n == CNT_W'(WEIGHT)) ||
                            to_fire;
                if (release_c) begin
                    state_n = ARB_IDLE;
                    gnt_n   = '0;
                    ptr_n   = SEL_W'(xbar_wrap_inc(int'(sel_q), NUM_MASTERS));
                    tout_n  = to_fire;
                end
            end
            default: begin
                state_n = ARB_IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            gnt_q   <= gnt_n;
            sel_q   <= sel_n;
            ptr_q   <= ptr_n;
            beat_q  <= beat_n;
            tout_q  <= tout_n;
        end
    end

    assign o_Gnt     = gnt_q;
    assign o_MuxSel  = sel_q;
    assign o_Busy    = (state_q == ARB_GRANT);
    assign o_Timeout = tout_q;

endmodule

// File: doc/xbar_wrr_slave_arbiter.md
Name: xbar_wrr_slave_arbiter

Overview:
- Per-slave weighted round-robin arbiter for the XbarV1 crossbar. It sits in front of each slave port and decides which master drives the slave mux.
- Each master, once granted, keeps ownership for up to WEIGHT completed transfers, or longer while it holds Lock.
- Grant and mux select are registered. An idle bubble is inserted between owners so the slave sees a clean hand-off.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (must be >= 2).
- WEIGHT, 4, transfers a master may complete per grant while Lock is low (must be >= 1).
- LOCK_TIMEOUT, 256, cycles without i_Ack that a locked owner may hold the slave (used only with the optional feature).
- SEL_W, $clog2(NUM_MASTERS), localparam, width of the mux select.

Ports:
- i_Clk  in  1  clock; all state updates on the rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Req  in  NUM_MASTERS  per-master request, level.
- i_Lock  in  NUM_MASTERS  per-master lock; extends the grant past the quota.
- i_Ack  in  1  slave completed one transfer for the current owner.
- o_Gnt  out  NUM_MASTERS  one-hot (or zero) grant, registered.
- o_MuxSel  out  SEL_W  index of the current or last owner, registered.
- o_Busy  out  1  high in the GRANT state.
- o_Timeout  out  1  one-cycle pulse when a locked owner is forcibly released.

Behaviour:
- Reset values (async assert):
  - o_Gnt=0, o_MuxSel=0, o_Busy=0, o_Timeout=0.
  - State=IDLE; round-robin pointer=0 (master 0 highest priority); beat counter=0; timeout counter=0; block mask=0.
- States: IDLE and GRANT.
- IDLE:
  - If any unmasked i_Req is high, pick the first requester scanning upward from the pointer, wrapping modulo NUM_MASTERS.
  - On the next edge: o_Gnt=onehot(winner), o_MuxSel=winner, state=GRANT, beat counter=0.
  - Request-to-grant latency is 1 cycle.
- GRANT:
  - i_Ack increments the beat counter. The counter saturates at WEIGHT.
  - Release occurs on the edge where any of these holds:
    - (a) i_Req[owner]=0, regardless of Lock;
    - (b) i_Lock[owner]=0 and the counter after this edge's update reaches WEIGHT;
    - (c) the timeout fires (optional feature).
  - On release: o_Gnt=0, o_Busy=0, state=IDLE, pointer=owner+1 (wraps to 0 after NUM_MASTERS-1).
  - o_MuxSel holds the old owner until the next grant.
  - Between owners there is always exactly one cycle with o_Gnt=0, including when the same master is re-granted.
- Lock behaviour:
  - Lock high with the counter at WEIGHT holds the grant.
  - Lock falling with the counter at WEIGHT releases on that edge.
- Simultaneous events:
  - i_Ack on the release edge is counted but has no further effect.
  - Requests arriving during GRANT wait; there is no preemption.
- i_Ack in IDLE is ignored.
- o_Gnt is never multi-hot.
- Reset mid-GRANT drops the grant immediately (asynchronous).

Optional Feature:
- Macro: XBAR_ARB_LOCK_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on every grant and on every i_Ack. It increments each GRANT cycle in which i_Lock[owner]=1 and i_Ack=0.
  - When the counter reaches LOCK_TIMEOUT-1 it forces a release and pulses o_Timeout for one cycle, aligned with o_Gnt falling.
  - The owner's bit is set in the block mask. Masked masters are excluded from arbitration until their i_Req is seen low, which clears the bit.
- Without the macro: no counter and no mask. o_Timeout is tied to 0. Lock may hold the slave indefinitely.

Decomposition:
- Shared package xbar_pkg: state encoding (ARB_IDLE, ARB_GRANT) and the onehot/index helper functions. Also used by the master-side decoder.
- One sub-module, xbar_rr_pick: combinational rotate-priority picker taking (req, mask, pointer) and returning winner index and valid.

Test Plan:
- Reset with i_Req=2'b11 held: o_Gnt=0 during reset; first edge after release gives o_Gnt=2'b01, o_MuxSel=0.
- Both requesting, Lock=0, i_Ack every cycle, WEIGHT=4: M0 owns 4 acks, then 1 idle cycle, M1 owns 4, then 1 idle, then M0 again.
- M0 locked, 6 acks: grant holds past 4. Lock falls: release on that edge; next grant goes to M1.
- M1 drops Req after 1 ack while locked: release on the next edge; pointer=0; M0 granted 1 cycle after the idle cycle.
- With XBAR_ARB_LOCK_TIMEOUT_EN and LOCK_TIMEOUT=8, M0 locked with no acks: o_Timeout pulses at grant+8 and M1 is granted. M0 is not re-granted until its Req toggles low.
- Assert i_Rst_n=0 mid-grant between edges: o_Gnt clears immediately; after release, arbitration restarts from pointer 0.
